// File: rtl/rx_frame_controller.sv
// rtl/rx_frame_controller.sv - UART receive frame sequencer with frame descriptor FIFO
//
// Groups received bytes into frames that close after a programmable idle gap.
// It counts the gap in bit times. Each closed frame pushes a descriptor
// {byte count, ms stamp, 0.1 ms stamp} into a first-word-fall-through FIFO.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   p_Enable_i                receive core enable
//   p_FrameFunctionEnable_i   frame function enable (qualified with p_Enable_i)
//   n_Clr_i                   active-low synchronous clear of FIFO and overflow flag
//   Byte_Synch_i              1-clk pulse per received byte
//   BaudSig_i                 1-clk pulse per bit time
//   FrameGapBits_i            idle bit times that close a frame (0 behaves as 1)
//   millisecond_stamp_i       ms timestamp
//   acqurate_stamp_i          0.1 ms timestamp
//   n_RxFrameInfo_Rd_i        active-low pop of the descriptor FIFO head
//   RxFrameInfo_o             head descriptor, 0 when empty
//   p_RxFrame_Empty_o         FIFO empty
//   p_RxFrame_Full_o          FIFO full
//   p_RxFrame_Over_o          sticky: a descriptor was dropped on a full FIFO
//   p_FrameEnd_o              1-clk pulse in the commit cycle
//   FrameLevel_o              number of descriptors held
module rx_frame_controller #(
    parameter int FRAME_DEPTH = 8,
    parameter int PTR_W       = 3,
    parameter int CNT_W       = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               p_Enable_i,
    input  logic               p_FrameFunctionEnable_i,
    input  logic               n_Clr_i,
    input  logic               Byte_Synch_i,
    input  logic               BaudSig_i,
    input  logic [7:0]         FrameGapBits_i,
    input  logic [11:0]        millisecond_stamp_i,
    input  logic [3:0]         acqurate_stamp_i,
    input  logic               n_RxFrameInfo_Rd_i,
    output logic [27:0]        RxFrameInfo_o,
    output logic               p_RxFrame_Empty_o,
    output logic               p_RxFrame_Full_o,
    output logic               p_RxFrame_Over_o,
    output logic               p_FrameEnd_o,
    output logic [PTR_W:0]     FrameLevel_o
);

    localparam logic [PTR_W:0] DEPTH_LVL = (PTR_W+1)'(FRAME_DEPTH);

    typedef enum logic [2:0] {
        IDLE    = 3'b001,
        INFRAME = 3'b010,
        COMMIT  = 3'b100
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   byte_cnt_q;
    logic [7:0]         gap_q;
    logic [15:0]        stamp_q;
    logic               frame_end_q;

    logic [27:0]        mem_q [FRAME_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W:0]     level_q;
    logic               over_q;

    logic               active;
    logic [8:0]         gap_inc;
    logic [8:0]         gap_limit;
    logic [15:0]        stamp_now;
    logic               fifo_full;
    logic               fifo_pop;
    logic               fifo_push;
    logic               fifo_drop;

    assign active    = p_Enable_i & p_FrameFunctionEnable_i;
    assign gap_inc   = {1'b0, gap_q} + 9'd1;
    // A programmed gap of zero would close every frame instantly; treat it as one bit time.
    assign gap_limit = (FrameGapBits_i == 8'd0) ? 9'd1 : {1'b0, FrameGapBits_i};
    assign stamp_now = {millisecond_stamp_i, acqurate_stamp_i};

    assign fifo_full = (level_q == DEPTH_LVL);
    assign fifo_pop  = ~n_RxFrameInfo_Rd_i & (level_q != '0);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign fifo_push = (state_q == COMMIT) & (~fifo_full | fifo_pop);
    assign fifo_drop = (state_q == COMMIT) & fifo_full & ~fifo_pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            byte_cnt_q  <= '0;
            gap_q       <= '0;
            stamp_q     <= '0;
            frame_end_q <= 1'b0;
        end else if (!active) begin
            // Any partially assembled frame is thrown away.
            state_q     <= IDLE;
            byte_cnt_q  <= '0;
            gap_q       <= '0;
            stamp_q     <= '0;
            frame_end_q <= 1'b0;
        end else begin
            frame_end_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Byte_Synch_i) begin
                        state_q    <= INFRAME;
                        byte_cnt_q <= CNT_W'(1);
                        gap_q      <= '0;
                        stamp_q    <= stamp_now;
                    end
                end
                INFRAME: begin
                    // A byte in the same cycle as a baud tick restarts the gap.
                    if (Byte_Synch_i) begin
                        if (byte_cnt_q != '1) begin
                            byte_cnt_q <= byte_cnt_q + 1'b1;
                        end
                        gap_q   <= '0;
                        stamp_q <= stamp_now;
                    end else if (BaudSig_i) begin
                        if (gap_q != 8'hFF) begin
                            gap_q <= gap_q + 1'b1;
                        end
                        if (gap_inc >= gap_limit) begin
                            state_q     <= COMMIT;
                            frame_end_q <= 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    // A byte arriving while the previous frame commits opens the next frame.
                    if (Byte_Synch_i) begin
                        state_q    <= INFRAME;
                        byte_cnt_q <= CNT_W'(1);
                        gap_q      <= '0;
                        stamp_q    <= stamp_now;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            over_q   <= 1'b0;
        end else if (!n_Clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            over_q   <= 1'b0;
        end else begin
            if (fifo_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({fifo_push, fifo_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
            if (fifo_drop) begin
                over_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset: the output is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (fifo_push && n_Clr_i) begin
            mem_q[wr_ptr_q] <= {byte_cnt_q, stamp_q};
        end
    end

    assign RxFrameInfo_o     = (level_q == '0) ? 28'd0 : mem_q[rd_ptr_q];
    assign p_RxFrame_Empty_o = (level_q == '0);
    assign p_RxFrame_Full_o  = fifo_full;
    assign p_RxFrame_Over_o  = over_q;
    assign p_FrameEnd_o      = frame_end_q;
    assign FrameLevel_o      = level_q;

endmodule

// File: tb/tb_rx_frame_controller.sv
// tb/tb_rx_frame_controller.sv - self-checking bench for rx_frame_controller
module tb_rx_frame_controller;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b1;
    logic        ffe = 1'b1;
    logic        n_clr = 1'b1;
    logic        bs = 1'b0;
    logic        baud = 1'b0;
    logic        n_rd = 1'b1;
    logic [7:0]  gapbits = 8'd4;
    logic [11:0] ms = 12'd0;
    logic [3:0]  acq = 4'd0;

    logic [27:0] info;
    logic        empty, full, over, fe;
    logic [3:0]  level;

    int checks = 0;
    int failures = 0;
    int fe_count = 0;

    always #5 clk = ~clk;

    rx_frame_controller #(.FRAME_DEPTH(8), .PTR_W(3), .CNT_W(12)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .p_Enable_i              (en),
        .p_FrameFunctionEnable_i (ffe),
        .n_Clr_i                 (n_clr),
        .Byte_Synch_i            (bs),
        .BaudSig_i               (baud),
        .FrameGapBits_i          (gapbits),
        .millisecond_stamp_i     (ms),
        .acqurate_stamp_i        (acq),
        .n_RxFrameInfo_Rd_i      (n_rd),
        .RxFrameInfo_o           (info),
        .p_RxFrame_Empty_o       (empty),
        .p_RxFrame_Full_o        (full),
        .p_RxFrame_Over_o        (over),
        .p_FrameEnd_o            (fe),
        .FrameLevel_o            (level)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Behavioural model: an open/committing frame plus a queue of descriptors.
    logic [27:0] m_q[$];
    bit          m_open = 1'b0;
    bit          m_commit = 1'b0;
    bit          m_over = 1'b0;
    logic [11:0] m_cnt = 12'd0;
    int          m_gap = 0;
    logic [15:0] m_stamp = 16'd0;

    initial begin : model
        logic [27:0] desc;
        int          thr;
        bit          pop;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_q.delete();
                m_open = 1'b0; m_commit = 1'b0; m_over = 1'b0;
                m_cnt = 12'd0; m_gap = 0; m_stamp = 16'd0;
            end else begin
                desc = {m_cnt, m_stamp};
                pop  = !n_rd && (m_q.size() > 0);
                if (!n_clr) begin
                    m_q.delete();
                    m_over = 1'b0;
                end else begin
                    if (pop) void'(m_q.pop_front());
                    if (m_commit) begin
                        if (m_q.size() < DEPTH) m_q.push_back(desc);
                        else m_over = 1'b1;
                    end
                end
                thr = (gapbits == 8'd0) ? 1 : int'(gapbits);
                if (!(en && ffe)) begin
                    m_open = 1'b0; m_commit = 1'b0;
                end else if (bs) begin
                    if (!m_open) m_cnt = 12'd1;
                    else if (m_cnt < 12'd4095) m_cnt = m_cnt + 12'd1;
                    m_gap = 0; m_stamp = {ms, acq};
                    m_open = 1'b1; m_commit = 1'b0;
                end else if (m_commit) begin
                    m_commit = 1'b0;
                end else if (m_open && baud) begin
                    m_gap++;
                    if (m_gap >= thr) begin
                        m_open = 1'b0; m_commit = 1'b1;
                    end
                end
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("info",      info,  (m_q.size() > 0) ? m_q[0] : 28'd0);
                chk("empty",     empty, m_q.size() == 0);
                chk("full",      full,  m_q.size() == DEPTH);
                chk("over",      over,  m_over);
                chk("frame_end", fe,    m_commit);
                chk("level",     level, m_q.size());
                if (fe) fe_count++;
            end
        end
    end

    task automatic cyc(input bit b, input bit bd, input bit rd_n);
        bs = b; baud = bd; n_rd = rd_n;
        @(posedge clk);
        #1;
        bs = 1'b0; baud = 1'b0; n_rd = 1'b1;
    endtask

    task automatic put_byte(input logic [11:0] m, input logic [3:0] a);
        ms = m; acq = a;
        cyc(1'b1, 1'b0, 1'b1);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            cyc(1'b0, 1'b1, 1'b1);
            cyc(1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic clr();
        n_clr = 1'b0;
        cyc(1'b0, 1'b0, 1'b1);
        n_clr = 1'b1;
    endtask

    initial begin : stim
        int f0;
        #1;
        chk("rst_info", info, 28'd0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_over", over, 1'b0);
        chk("rst_fe", fe, 1'b0);
        chk("rst_level", level, 4'd0);
        #11 rst = 1'b1;
        @(posedge clk); #1;

        // Basic frame
        gapbits = 8'd4;
        put_byte(12'd100, 4'd2);
        ticks(1);
        put_byte(12'd101, 4'd3);
        put_byte(12'd102, 4'd7);
        f0 = fe_count;
        ticks(4);
        chk("basic_fe_pulses", fe_count - f0, 1);
        chk("basic_info", info, 28'h0030667);
        chk("basic_empty", empty, 1'b0);
        chk("basic_level", level, 4'd1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("basic_read_empty", empty, 1'b1);

        // Gap boundary: 3 idle ticks do not close a gap of 4
        put_byte(12'd200, 4'd1);
        ticks(3);
        chk("gap3_no_commit", level, 4'd0);
        put_byte(12'd201, 4'd2);
        ticks(4);
        chk("gap_cont_info", info, 28'h0020C92);
        cyc(1'b0, 1'b0, 1'b0);

        // Gap of zero acts as one
        gapbits = 8'd0;
        put_byte(12'd300, 4'd4);
        ticks(1);
        chk("gap0_info", info, 28'h00112C4);
        cyc(1'b0, 1'b0, 1'b0);

        // Byte and baud in one cycle: byte wins
        gapbits = 8'd2;
        put_byte(12'd10, 4'd1);
        ticks(1);
        ms = 12'd11; acq = 4'd2;
        cyc(1'b1, 1'b1, 1'b1);
        ticks(1);
        chk("byte_wins_no_commit", level, 4'd0);
        ticks(1);
        chk("byte_wins_info", info, 28'h00200B2);
        cyc(1'b0, 1'b0, 1'b0);

        // Byte during the commit cycle opens the next frame
        gapbits = 8'd1;
        put_byte(12'd20, 4'd0);
        cyc(1'b0, 1'b1, 1'b1);
        ms = 12'd500; acq = 4'd5;
        cyc(1'b1, 1'b0, 1'b1);
        ticks(1);
        chk("commit_byte_level", level, 4'd2);
        chk("commit_byte_first", info, 28'h0010140);
        cyc(1'b0, 1'b0, 1'b0);
        chk("commit_byte_second", info, 28'h0011F45);
        cyc(1'b0, 1'b0, 1'b0);

        // Disable mid-frame discards it
        gapbits = 8'd4;
        put_byte(12'd30, 4'd0);
        put_byte(12'd31, 4'd0);
        ffe = 1'b0;
        cyc(1'b0, 1'b0, 1'b1);
        ffe = 1'b1;
        ticks(4);
        chk("disable_drop", level, 4'd0);

        // Clear with 3 entries
        gapbits = 8'd1;
        for (int i = 0; i < 3; i++) begin
            put_byte(12'(i), 4'd0);
            ticks(1);
        end
        chk("clr3_level_before", level, 4'd3);
        clr();
        chk("clr3_empty", empty, 1'b1);
        chk("clr3_level", level, 4'd0);
        chk("clr3_over", over, 1'b0);

        // Overflow: 9 commits, no reads
        for (int i = 1; i <= 9; i++) begin
            put_byte(12'(i), 4'd0);
            ticks(1);
        end
        chk("ovf_level", level, 4'd8);
        chk("ovf_full", full, 1'b1);
        chk("ovf_over", over, 1'b1);
        chk("ovf_head", info, 28'h0010010);
        clr();
        chk("ovf_clr_over", over, 1'b0);

        // 9th commit coinciding with a read is accepted
        for (int i = 1; i <= 8; i++) begin
            put_byte(12'(i), 4'd0);
            ticks(1);
        end
        put_byte(12'd9, 4'd0);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("full_rw_level", level, 4'd8);
        chk("full_rw_over", over, 1'b0);
        chk("full_rw_head", info, 28'h0010020);
        clr();

        // Byte count saturates at 4095
        gapbits = 8'd4;
        repeat (5000) put_byte(12'd7, 4'd7);
        ticks(4);
        chk("sat_info", info, 28'hFFF0077);
        clr();

        // Asynchronous reset mid-frame
        gapbits = 8'd1;
        put_byte(12'd1, 4'd1);
        ticks(1);
        gapbits = 8'd4;
        repeat (5) put_byte(12'd40, 4'd0);
        #3 rst = 1'b0;
        #1;
        chk("arst_info", info, 28'd0);
        chk("arst_empty", empty, 1'b1);
        chk("arst_full", full, 1'b0);
        chk("arst_over", over, 1'b0);
        chk("arst_fe", fe, 1'b0);
        chk("arst_level", level, 4'd0);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        gapbits = 8'd1;
        put_byte(12'd50, 4'd0);
        ticks(1);
        chk("arst_first_frame", info, 28'h0010320);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rx_frame_controller.md
Name: rx_frame_controller

Overview:
Frame sequencer for the UART receive path. It watches the per-byte strobe from the receive shift register and the baud tick, and groups bytes into frames. A frame closes after a programmable idle gap measured in bit times. For each frame it pushes a 28-bit frame descriptor (byte count plus the timestamp of the last byte) into a small internal descriptor FIFO. The host reads that FIFO alongside the receive data FIFO, and it drives the RxFrameInfo / frame-empty status of the receive core.

Parameters:
FRAME_DEPTH, 8, number of descriptor FIFO entries; must be a power of 2, minimum 2.
PTR_W, 3, log2(FRAME_DEPTH).
CNT_W, 12, width of the byte counter in the descriptor (fixed at 12 for the 28-bit format).

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous reset, active-low
p_Enable_i  input  1  receive core enable
p_FrameFunctionEnable_i  input  1  frame function enable; the block works only while this and p_Enable_i are both high
n_Clr_i  input  1  active-low synchronous clear of the descriptor FIFO and the overflow flag
Byte_Synch_i  input  1  1-clk pulse, one valid byte received
BaudSig_i  input  1  1-clk pulse per bit time
FrameGapBits_i  input  8  idle bit times that close a frame; 0 is treated as 1
millisecond_stamp_i  input  12  ms timestamp, 0..999
acqurate_stamp_i  input  4  0.1 ms timestamp, 0..9
n_RxFrameInfo_Rd_i  input  1  active-low, 1-clk pulse, pops the descriptor FIFO head
RxFrameInfo_o  output  28  head descriptor: [27:16] byte count, [15:4] ms stamp, [3:0] 0.1 ms stamp
p_RxFrame_Empty_o  output  1  descriptor FIFO empty
p_RxFrame_Full_o  output  1  descriptor FIFO full
p_RxFrame_Over_o  output  1  sticky flag, a descriptor was dropped because the FIFO was full
p_FrameEnd_o  output  1  1-clk pulse in the COMMIT cycle
FrameLevel_o  output  PTR_W+1  number of descriptors held

Behaviour:
- Reset (rst low, asynchronous):
  - State IDLE; byte counter, gap counter and stamp latch cleared; FIFO pointers cleared.
  - RxFrameInfo_o=0, p_RxFrame_Empty_o=1, p_RxFrame_Full_o=0, p_RxFrame_Over_o=0, p_FrameEnd_o=0, FrameLevel_o=0.
- Active = p_Enable_i & p_FrameFunctionEnable_i.
  - Active low: state forced to IDLE next clock and any partial frame is discarded.
  - The FIFO contents and reads are unaffected by Active.
- State machine (one-hot, 3 states: IDLE, INFRAME, COMMIT):
  - IDLE: Byte_Synch_i -> INFRAME; byte count=1, gap=0, latch {ms, acq}.
  - INFRAME:
    - Byte_Synch_i -> byte count+1, saturating at 4095; gap=0; re-latch the stamp.
    - BaudSig_i without Byte_Synch_i -> gap+1.
    - When gap+1 >= max(FrameGapBits_i,1) -> COMMIT.
    - Byte_Synch_i and BaudSig_i in the same cycle: the byte wins and gap=0.
  - COMMIT (exactly 1 cycle):
    - p_FrameEnd_o=1.
    - Push {count, stamp} if the FIFO is not full or a pop happens the same cycle; otherwise drop the descriptor and set p_RxFrame_Over_o.
    - Next state IDLE; if Byte_Synch_i occurs in the COMMIT cycle, next state is INFRAME with count=1 and the new stamp latched (that byte is not lost).
- Gap counter is 8 bits and saturates; it counts only in INFRAME.
- Descriptor FIFO:
  - First-word fall-through: RxFrameInfo_o shows the head entry combinationally from registered storage; it is 0 when empty.
  - Pop on n_RxFrameInfo_Rd_i=0; a pop while empty is ignored and Over is not affected.
  - Push and pop in the same cycle: level unchanged, both take effect, including when full.
  - Pointers wrap modulo FRAME_DEPTH; full when level = FRAME_DEPTH.
  - Flags and level update the clock after the push or pop.
- n_Clr_i=0: pointers and level go to 0 and Over clears; the state machine is unaffected. Clear takes priority over a simultaneous push or pop.
- Latency:
  - Last gap baud tick -> COMMIT the next clock.
  - Descriptor visible and p_RxFrame_Empty_o=0 one clock after COMMIT.

Test Plan:
- Reset: assert rst low mid-frame (count 5) -> all outputs at reset values immediately; after release, the first byte starts count=1.
- Basic frame: gap=4, 3 bytes at stamps ms=100/acq=2, 101/3, 102/7, then 4 idle baud ticks -> one p_FrameEnd_o pulse, RxFrameInfo_o=28'h003_066_7, Empty=0, level 1; after a read, Empty=1.
- Gap boundary: gap=4 with a byte after 3 idle ticks -> no commit, count continues; FrameGapBits_i=0 -> commit after 1 idle tick.
- Overflow: FRAME_DEPTH=8, commit 9 frames with no reads -> level 8, Full=1, Over=1, head = frame 1; a 9th commit coinciding with a read -> accepted, Over stays 0.
- Simultaneous events: Byte_Synch_i and BaudSig_i in the same cycle -> gap reset; a byte in the COMMIT cycle -> next descriptor count includes that byte; 5000 bytes with no gap -> count 4095.
- Disable/clear: drop p_FrameFunctionEnable_i mid-frame -> no descriptor pushed; n_Clr_i pulse with 3 entries -> Empty=1, level 0, Over=0.
